// File: rtl/fetch_if.sv
// Handshake bundle between the IF stage and its neighbours: hazard controls, redirect,
// instruction memory port and the IF/ID register outputs seen by decode.
interface fetch_if;
  logic        stall_f;
  logic        flush_d;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_instruction;
  logic [31:0] imem_address;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        misalign_d;

  modport master (
    input  stall_f, flush_d, redirect_valid, redirect_target, imem_instruction,
    output imem_address, pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misalign_d
  );

  modport slave (
    output stall_f, flush_d, redirect_valid, redirect_target, imem_instruction,
    input  imem_address, pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misalign_d
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: program counter, word address to instruction memory and the
// IF/ID pipeline register with bubble insertion on flush or redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic     clk_i,
  input  logic     reset_n_i,
  fetch_if.master  bus
);

  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic        id_misalign_q, id_misalign_d;
  logic [31:0] pc_plus4_s;

  assign pc_plus4_s = pc_q + 32'd4;

  // PC next state: a redirect wins over stall so a resolved branch is never lost
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (bus.redirect_valid) begin
      pc_d       = {bus.redirect_target[31:2], 2'b00};
      misalign_d = |bus.redirect_target[1:0];
    end else if (bus.stall_f) begin
      pc_d       = pc_q;
      misalign_d = misalign_q;
    end else begin
      pc_d       = pc_plus4_s;
      misalign_d = 1'b0;
    end
  end

  // IF/ID next state: bubble on flush or redirect, hold on stall, otherwise load
  always_comb begin
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    id_misalign_d = id_misalign_q;
    if (bus.flush_d || bus.redirect_valid) begin
      id_instr_d    = NOP_INSTR;
      id_valid_d    = 1'b0;
      id_misalign_d = 1'b0;
    end else if (bus.stall_f) begin
      id_instr_d    = id_instr_q;
      id_valid_d    = id_valid_q;
      id_misalign_d = id_misalign_q;
    end else begin
      id_instr_d    = bus.imem_instruction;
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_plus4_s;
      id_valid_d    = 1'b1;
      id_misalign_d = misalign_q;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_q          <= RESET_PC;
      misalign_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 32'h0000_0000;
      id_pc_plus4_q <= 32'h0000_0000;
      id_valid_q    <= 1'b0;
      id_misalign_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      misalign_q    <= misalign_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      id_misalign_q <= id_misalign_d;
    end
  end

  assign bus.imem_address = {2'b00, pc_q[31:2]};
  assign bus.pc_f         = pc_q;
  assign bus.instr_d      = id_instr_q;
  assign bus.pc_d         = id_pc_q;
  assign bus.pc_plus4_d   = id_pc_plus4_q;
  assign bus.valid_d      = id_valid_q;
  assign bus.misalign_d   = id_misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural model pushes expected post-edge state
// into a scoreboard queue as each cycle's stimulus is driven; entries are popped after the edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic        mis;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        valid;
    logic        misd;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;
  exp_t m;
  exp_t sb_q[$];

  fetch_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus.master)
  );

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
  endfunction

  assign bus.imem_instruction = imem_fn(bus.imem_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pcF"},    bus.pc_f, 32'h0000_0000);
    check({tag, "_imem"},   bus.imem_address, 32'h0000_0000);
    check({tag, "_instr"},  bus.instr_d, NOP);
    check({tag, "_pcD"},    bus.pc_d, 32'h0000_0000);
    check({tag, "_pc4D"},   bus.pc_plus4_d, 32'h0000_0000);
    check({tag, "_valid"},  {31'd0, bus.valid_d}, 32'd0);
    check({tag, "_misD"},   {31'd0, bus.misalign_d}, 32'd0);
  endtask

  task automatic model_reset();
    m.pc = 32'h0000_0000; m.mis = 1'b0; m.instr = NOP;
    m.pcd = 32'h0000_0000; m.pc4 = 32'h0000_0000; m.valid = 1'b0; m.misd = 1'b0;
  endtask

  // Drive one cycle of stimulus, predict the post-edge state, then compare after the edge
  task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] tg);
    exp_t e;
    exp_t got;
    bus.stall_f = st;
    bus.flush_d = fl;
    bus.redirect_valid = rv;
    bus.redirect_target = tg;
    e = m;
    if (rv) begin
      e.pc = {tg[31:2], 2'b00};
      e.mis = |tg[1:0];
    end else if (!st) begin
      e.pc = m.pc + 32'd4;
      e.mis = 1'b0;
    end
    if (fl || rv) begin
      e.instr = NOP; e.valid = 1'b0; e.misd = 1'b0;
    end else if (!st) begin
      e.instr = imem_fn({2'b00, m.pc[31:2]});
      e.pcd = m.pc; e.pc4 = m.pc + 32'd4; e.valid = 1'b1; e.misd = m.mis;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("pcF",   bus.pc_f, got.pc);
    check("imem",  bus.imem_address, {2'b00, got.pc[31:2]});
    check("instrD", bus.instr_d, got.instr);
    check("pcD",   bus.pc_d, got.pcd);
    check("pc4D",  bus.pc_plus4_d, got.pc4);
    check("validD", {31'd0, bus.valid_d}, {31'd0, got.valid});
    check("misD",  {31'd0, bus.misalign_d}, {31'd0, got.misd});
    m = got;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus.stall_f = 1'b0;
    bus.flush_d = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0000_0000;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Sequential fetch 0,4,8,C,10
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    check("seq_pcF10", bus.pc_f, 32'h0000_0010);
    check("seq_pcD0C", bus.pc_d, 32'h0000_000C);
    // Two stall cycles at 0x10, then release
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_pcF", bus.pc_f, 32'h0000_0010);
    check("stall_pcD", bus.pc_d, 32'h0000_000C);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("unstall_pcD", bus.pc_d, 32'h0000_0010);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    // Redirect to 0x40 from 0x18
    check("pre_redir_pcF", bus.pc_f, 32'h0000_0018);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    check("redir_instr_nop", bus.instr_d, 32'h0000_0013);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("redir_pcD40", bus.pc_d, 32'h0000_0040);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    // Misaligned redirect 0x42 with stall asserted
    step(1'b1, 1'b0, 1'b1, 32'h0000_0042);
    check("mis_pcF40", bus.pc_f, 32'h0000_0040);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("mis_flag1", {31'd0, bus.misalign_d}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("mis_flag0", {31'd0, bus.misalign_d}, 32'd0);
    // Stall plus flush without redirect, then flush alone
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    // PC wrap
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_pcF", bus.pc_f, 32'h0000_0000);
    check("wrap_pcD", bus.pc_d, 32'hFFFF_FFFC);
    check("wrap_pc4D", bus.pc_plus4_d, 32'h0000_0000);
    // Mixed random hazards
    for (int i = 0; i < 12; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom & 32'h0000_0FFF);
    // Asynchronous reset between edges, during a stall
    bus.stall_f = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(posedge clk);
    #1;
    check_reset_outputs("hold");
    reset_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("restart_pcD", bus.pc_d, 32'h0000_0000);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
